uart_tx: RTL

//   Serialises one parallel byte per valid/ready handshake onto uart_txd as an 8N1-style

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_if.sv | 13 +
 rtl/uart_baud_tick.sv | 38 +++
 rtl/uart_tx.sv | 129 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and bit-period helpers.
// Used by both the transmitter and the receiver side.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Clocks per bit, truncated.
  function automatic int calc_cpb(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

  // Parity over a zero-padded payload; the padding does not change the XOR.
  function automatic logic calc_parity(input logic [7:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between board logic and the UART transmitter.
// The producer uses master; the transmitter uses slave.
interface uart_tx_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic                    tx_valid;
  logic                    tx_ready;
  logic [PAYLOAD_BITS-1:0] tx_data;
  logic                    tx_done;

  modport master (output tx_valid, output tx_data, input tx_ready, input tx_done);
  modport slave  (input tx_valid, input tx_data, output tx_ready, output tx_done);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CPB-1 and pulses tick on the last cycle of each bit.
// restart holds the counter at zero so a new frame starts on a clean bit boundary.
module uart_baud_tick #(
  parameter int CPB = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [W-1:0] LAST = W'(CPB - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !restart && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one payload per valid/ready handshake, sent as start bit,
// LSB-first data, optional parity and one or two stop bits on a registered line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus,
  output logic      uart_txd
);

  localparam int CPB = calc_cpb(CLK_HZ, BIT_RATE);
  localparam int BW  = $clog2(PAYLOAD_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(PAYLOAD_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_state_e             state_q, state_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic                    parity_q, parity_d;
  logic                    txd_q, txd_d;
  logic                    done_q, done_d;
  logic                    tick;
  logic                    accept;

  uart_baud_tick #(.CPB(CPB)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (state_q == ST_IDLE),
    .tick    (tick)
  );

  assign accept = bus.tx_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_START;
          shift_d   = bus.tx_data;
          parity_d  = calc_parity(8'(bus.tx_data), PARITY);
          bit_cnt_d = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Line level follows the state being entered so the pin changes on the same edge.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
      ST_PARITY: txd_d = parity_d;
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      txd_q     <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      txd_q     <= txd_d;
      done_q    <= done_d;
    end
  end

  assign uart_txd     = txd_q;
  assign bus.tx_ready = (state_q == ST_IDLE);
  assign bus.tx_done  = done_q;

endmodule
